// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and the PLL / reset network.
// The master modport is the sequencer: it consumes the PLL lock and drives all resets and status.
interface pll_reset_sequencer_if;
    logic       pll_locked;
    logic       pll_rst;
    logic       core_rst_n;
    logic       periph_rst_n;
    logic       ready;
    logic       fail;
    logic [3:0] retry_count;
    logic       lock_lost;

    modport master (
        input  pll_locked,
        output pll_rst,
        output core_rst_n,
        output periph_rst_n,
        output ready,
        output fail,
        output retry_count,
        output lock_lost
    );

    modport slave (
        output pll_locked,
        input  pll_rst,
        input  core_rst_n,
        input  periph_rst_n,
        input  ready,
        input  fail,
        input  retry_count,
        input  lock_lost
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL supervisor: pulses the PLL reset, debounces lock and releases the core and then the peripheral
// resets in stages. It retries the PLL on lock timeout and re-sequences when lock is lost.
module pll_reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int RELEASE_GAP    = 16,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pll_reset_sequencer_if.master bus
);
    localparam int MAX_AB  = (PLL_RST_CYCLES > TIMEOUT_CYCLES) ? PLL_RST_CYCLES : TIMEOUT_CYCLES;
    localparam int MAX_CD  = (STABLE_CYCLES > RELEASE_GAP) ? STABLE_CYCLES : RELEASE_GAP;
    localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        ST_PLL_RESET,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RELEASE,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   pll_rst_q, pll_rst_d;
    logic                   core_rst_n_q, core_rst_n_d;
    logic                   periph_rst_n_q, periph_rst_n_d;
    logic                   ready_q, ready_d;
    logic                   fail_q, fail_d;
    logic [3:0]             retry_count_q, retry_count_d;
    logic                   lock_lost_q, lock_lost_d;
    logic                   lock_s;
    logic                   lock_drop;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_d[gi] = bus.pll_locked;
            end else begin : g_next
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    assign lock_s    = sync_q[SYNC_STAGES-1];
    assign lock_drop = ((state_q == ST_RELEASE) || (state_q == ST_RUN)) && !lock_s;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q + 1'b1;
        pll_rst_d      = pll_rst_q;
        core_rst_n_d   = core_rst_n_q;
        periph_rst_n_d = periph_rst_n_q;
        ready_d        = ready_q;
        fail_d         = fail_q;
        retry_count_d  = retry_count_q;
        lock_lost_d    = lock_lost_q;

        // Lock loss after core release outranks a RELEASE gap completing on the same cycle.
        if (lock_drop) begin
            state_d        = ST_PLL_RESET;
            pll_rst_d      = 1'b1;
            core_rst_n_d   = 1'b0;
            periph_rst_n_d = 1'b0;
            ready_d        = 1'b0;
            lock_lost_d    = 1'b1;
            retry_count_d  = 4'd0;
        end else begin
            case (state_q)
                ST_PLL_RESET: begin
                    if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
                        state_d   = ST_WAIT_LOCK;
                        pll_rst_d = 1'b0;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_STABLE;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        pll_rst_d = 1'b1;
                        if (retry_count_q == 4'(MAX_RETRIES)) begin
                            state_d = ST_FAIL;
                            fail_d  = 1'b1;
                        end else begin
                            state_d       = ST_PLL_RESET;
                            retry_count_d = retry_count_q + 4'd1;
                        end
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                        state_d      = ST_RELEASE;
                        core_rst_n_d = 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == CNT_W'(RELEASE_GAP - 1)) begin
                        state_d        = ST_RUN;
                        periph_rst_n_d = 1'b1;
                        ready_d        = 1'b1;
                    end
                end
                ST_RUN: begin
                    cnt_d = cnt_q;
                end
                ST_FAIL: begin
                    cnt_d = cnt_q;
                end
                default: begin
                    state_d = ST_PLL_RESET;
                end
            endcase
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_PLL_RESET;
            cnt_q          <= '0;
            sync_q         <= '0;
            pll_rst_q      <= 1'b1;
            core_rst_n_q   <= 1'b0;
            periph_rst_n_q <= 1'b0;
            ready_q        <= 1'b0;
            fail_q         <= 1'b0;
            retry_count_q  <= 4'd0;
            lock_lost_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sync_q         <= sync_d;
            pll_rst_q      <= pll_rst_d;
            core_rst_n_q   <= core_rst_n_d;
            periph_rst_n_q <= periph_rst_n_d;
            ready_q        <= ready_d;
            fail_q         <= fail_d;
            retry_count_q  <= retry_count_d;
            lock_lost_q    <= lock_lost_d;
        end
    end

    assign bus.pll_rst      = pll_rst_q;
    assign bus.core_rst_n   = core_rst_n_q;
    assign bus.periph_rst_n = periph_rst_n_q;
    assign bus.ready        = ready_q;
    assign bus.fail         = fail_q;
    assign bus.retry_count  = retry_count_q;
    assign bus.lock_lost    = lock_lost_q;
endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Supervises the video/core PLL and generates the reset network for everything clocked by the PLL outputs.
- Runs on the free-running 50 MHz board reference clock.
- Drives the PLL reset input and synchronises/debounces the PLL `locked` output.
- Releases core and peripheral resets in stages once lock is stable; retries the PLL on lock timeout and re-sequences on lock loss.

Parameters:
- SYNC_STAGES, 2: flops in the `pll_locked` synchroniser (≥2).
- PLL_RST_CYCLES, 16: cycles `pll_rst` is held high per attempt (≥1).
- TIMEOUT_CYCLES, 1000000: cycles allowed in WAIT_LOCK before a retry (20 ms at 50 MHz).
- STABLE_CYCLES, 1024: consecutive synchronised-lock-high cycles required before release.
- RELEASE_GAP, 16: cycles between `core_rst_n` and `periph_rst_n` release (≥1).
- MAX_RETRIES, 3: retries after the first attempt before entering FAIL (0..15).

Ports:
- clk  in  1  50 MHz free-running reference clock.
- rst_n  in  1  synchronous active-low reset.
- pll_locked  in  1  PLL locked, asynchronous to clk.
- pll_rst  out  1  active-high reset to the PLL.
- core_rst_n  out  1  active-low reset for the core domain.
- periph_rst_n  out  1  active-low reset for peripherals; released after the core.
- ready  out  1  high in RUN only.
- fail  out  1  high in FAIL only.
- retry_count  out  4  retries performed in the current sequence.
- lock_lost  out  1  sticky; set on any lock drop after core release.

Behaviour:
- Reset and synchronisation:
  - Reset is synchronous, active-low, and applies to every flop.
  - Reset values: pll_rst=1, core_rst_n=0, periph_rst_n=0, ready=0, fail=0, retry_count=0, lock_lost=0, synchroniser=0, state=PLL_RESET, cnt=0.
  - `lock_s` is the output of the SYNC_STAGES flop chain. Only `lock_s` is used internally.
- Counter and outputs:
  - A single counter `cnt` is cleared on every state change.
  - `cnt` is sized to the maximum of the count parameters.
  - All outputs are registered and change on the same edge as the state change.
- States:
  - PLL_RESET: pll_rst=1. When cnt==PLL_RST_CYCLES-1, go to WAIT_LOCK (pll_rst=0 from that edge).
  - WAIT_LOCK:
    - lock_s=1: go to STABLE.
    - lock_s=0 and cnt==TIMEOUT_CYCLES-1: if retry_count==MAX_RETRIES go to FAIL; else increment retry_count and go to PLL_RESET.
  - STABLE:
    - lock_s=0: go to WAIT_LOCK (timeout restarts; retry_count unchanged).
    - lock_s=1 and cnt==STABLE_CYCLES-1: go to RELEASE and set core_rst_n=1.
  - RELEASE: when cnt==RELEASE_GAP-1, set periph_rst_n=1 and ready=1, and go to RUN.
  - RUN: idle while lock_s=1.
  - FAIL: terminal. pll_rst=1, both resets asserted, fail=1. Only rst_n exits FAIL.
- Lock loss in RELEASE or RUN (lock_s=0):
  - On the next edge: core_rst_n=0, periph_rst_n=0, ready=0, lock_lost=1.
  - retry_count clears to 0 and the state goes to PLL_RESET.
  - Lock-loss handling takes priority over the RELEASE gap completion in the same cycle.
- Latency:
  - Take edge 0 as the first edge at which the first sync flop samples pll_locked=1, with the FSM in WAIT_LOCK and lock held.
  - STABLE is entered at edge SYNC_STAGES.
  - core_rst_n rises at edge SYNC_STAGES+STABLE_CYCLES.
  - periph_rst_n and ready rise RELEASE_GAP edges later.
- Ordering and invariants:
  - core_rst_n is never 0 while periph_rst_n is 1.
  - pll_rst is never 1 while core_rst_n is 1.
- Asynchronous input: a glitch on pll_locked shorter than one clk period may or may not be captured. Either outcome must leave the FSM in a legal state.
- Reset mid-operation: rst_n=0 in any state forces the reset values on the next edge.

Test Plan:
All directed tests use SYNC_STAGES=2, PLL_RST_CYCLES=4, TIMEOUT_CYCLES=32, STABLE_CYCLES=8, RELEASE_GAP=4, MAX_RETRIES=2.
- Clean lock:
  - Stimulus: release rst_n; raise pll_locked 10 cycles after pll_rst falls and hold it high.
  - Required: pll_rst high for exactly 4 cycles after reset release; core_rst_n rises 10 edges after lock is first sampled; periph_rst_n and ready rise 4 edges later; retry_count=0; lock_lost=0.
- Lock timeout then success:
  - Stimulus: keep pll_locked low; raise it during the 2nd WAIT_LOCK.
  - Required: after 32 WAIT_LOCK cycles pll_rst pulses high for 4 cycles; retry_count=1; normal release follows.
- Permanent failure:
  - Stimulus: pll_locked held at 0.
  - Required: 3 WAIT_LOCK windows separated by 2 pll_rst pulses, then fail=1 and pll_rst=1 held; retry_count=2; core_rst_n=0 indefinitely.
- Chatter during STABLE:
  - Stimulus: drop pll_locked for 3 cycles after 5 stable cycles.
  - Required: return to WAIT_LOCK with no pll_rst pulse; core_rst_n released only after 8 fresh consecutive high cycles.
- Lock loss in RUN:
  - Stimulus: drop pll_locked while in RUN.
  - Required: core_rst_n, periph_rst_n and ready go low 3 edges after the drop (2 sync + 1); lock_lost=1 sticky; pll_rst pulses for 4 cycles; retry_count=0.
- Reset mid-sequence:
  - Stimulus: assert rst_n in RELEASE (core_rst_n=1, periph_rst_n=0).
  - Required: next edge gives all reset values; lock_lost=0; the sequence restarts from PLL_RESET.
